audio_sample_unpack: RTL and testbench
======================================

Name: audio_sample_unpack

Overview:
- Sits between the 8-bit audio byte FIFO (fed by the SPI flash reader) and the S/PDIF transmitter.
- Pops bytes from the FIFO and assembles them into complete mono or stereo PCM frames.
- Buffers one complete frame and presents left/right samples to the transmitter on each transmitter ack.
- Counts underruns: acks that arrive with no complete frame buffered.

Parameters:
OUT_W, 24, output sample width; must be >= 16; samples are left-justified.
UCNT_W, 16, underrun counter width.

Ports:
clk  in  1  system clock (clk_1x domain)
rst  in  1  synchronous active-high reset
enable  in  1  1 = stream from FIFO; 0 = idle, output silence
fmt  in  2  00 8-bit mono, 01 16-bit LE mono, 10 16-bit LE stereo (L lo, L hi, R lo, R hi), 11 8-bit stereo (L, R)
fifo_data  in  8  FIFO read data; first-word-fall-through, valid whenever fifo_empty=0
fifo_empty  in  1  FIFO empty flag
fifo_rena  out  1  FIFO pop strobe
audio_l  out  OUT_W  left sample to transmitter
audio_r  out  OUT_W  right sample to transmitter
audio_valid  out  1  sample valid to transmitter
audio_ack  in  1  transmitter consumed current sample, 1-cycle pulse
underrun_cnt  out  UCNT_W  saturating underrun count
underrun_clr  in  1  clear underrun_cnt

Behaviour:
- One clock (clk); rst is synchronous, active-high.
- Reset state: audio_l=0, audio_r=0, audio_valid=0, underrun_cnt=0, byte_idx=0, staged_valid=0, en_q=0, fmt_q=00.
- Registered enable: en_q <= enable; audio_valid <= enable.
- Format latch: fmt_q <= fmt only while en_q=0. Changes to fmt while enabled are ignored.
- Bytes per frame N: 00→1, 01→2, 10→4, 11→2. byte_idx counts 0..N-1.
- Pop condition: fifo_rena = en_q & ~fifo_empty & (byte_idx != N-1 | ~staged_valid | audio_ack). This is combinational from registered state, fifo_empty and audio_ack.
- On each pop:
  - fifo_data is written into assembly byte[byte_idx].
  - If byte_idx != N-1, byte_idx increments.
  - Otherwise byte_idx <= 0, the staging register <= converted frame, staged_valid <= 1.
- Conversion to staged L/R, all samples left-justified and zero-padded to OUT_W:
  - 8-bit sample b → {b, b, 0...}, i.e. byte replicated.
  - 16-bit sample → {hi, lo, 0...}.
  - Mono formats: R = L.
  - The last byte is taken directly from fifo_data in the completing cycle.
- On audio_ack:
  - en_q=1 and staged_valid=1: audio_l/r <= staged; staged_valid <= 0, unless a frame completes in the same cycle, in which case it stays 1 with the new frame.
  - en_q=1 and staged_valid=0: underrun. audio_l/r <= 0; underrun_cnt increments, saturating at all-ones.
  - en_q=0: audio_l/r <= 0; no underrun counted.
- Outputs change only on audio_ack or rst.
- Latency: a frame's last byte popped at cycle t → staged at edge t+1 → on audio_l/r at the first audio_ack edge after that.
- Disable (en_q=0): byte_idx <= 0, staged_valid <= 0; partial and staged frames are discarded; no pops.
- Re-enable: assembly restarts at byte 0 of the next FIFO byte.
- underrun_clr: underrun_cnt <= 0. Clear wins over a simultaneous increment.
- FIFO empty mid-frame: assembly holds its partial state indefinitely. No timeout, no realignment.
- rst mid-frame: all state returns to reset values immediately; the FIFO is not touched.

Test Plan:
1. fmt=00, enable=1, FIFO preloaded 0x12,0x34, two acks 10 cycles apart → audio_l=audio_r=0x121200 then 0x343400; 2 pops total; underrun_cnt=0.
2. fmt=10, FIFO 0x01,0x80,0xFF,0x7F, ack after fill → audio_l=0x800100, audio_r=0x7FFF00; exactly 4 pops; no 5th pop while staged full and no ack.
3. fmt=01, FIFO empty, 3 acks → audio_l/r=0 each time; underrun_cnt=3. Then underrun_clr asserted together with a 4th underrunning ack → underrun_cnt=0.
4. fmt=11, continuous FIFO supply with ack on the same cycle as the last byte of the next frame → old staged frame is output, new frame staged, no underrun, no dropped or duplicated frame over 100 frames.
5. fmt=10, after 2 of 4 bytes popped, deassert enable, change fmt to 00, re-enable, FIFO next byte 0x55 → partial discarded; next ack gives audio_l=audio_r=0x555500.
6. Force underrun_cnt to 0xFFFF via 65535+ underruns (UCNT_W=16), one more underrun → stays 0xFFFF. Assert rst mid-frame → all outputs 0, fifo_rena=0 in the following cycle while enable=0.

Source files
------------

// File: rtl/audio_sample_unpack.sv
// Unpacks FIFO bytes into mono/stereo PCM frames, buffers one frame and hands
// left/right samples to the S/PDIF transmitter on each ack.
module audio_sample_unpack #(
    parameter int unsigned OUT_W  = 24,
    parameter int unsigned UCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        fmt,
    input  logic [7:0]        fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rena,
    output logic [OUT_W-1:0]  audio_l,
    output logic [OUT_W-1:0]  audio_r,
    output logic              audio_valid,
    input  logic              audio_ack,
    output logic [UCNT_W-1:0] underrun_cnt,
    input  logic              underrun_clr
);

    localparam logic [1:0] FMT_MONO8    = 2'b00;
    localparam logic [1:0] FMT_MONO16   = 2'b01;
    localparam logic [1:0] FMT_STEREO16 = 2'b10;
    localparam logic [1:0] FMT_STEREO8  = 2'b11;

    logic              en_q;
    logic [1:0]        fmt_q, fmt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [3:0][7:0]   asm_q, asm_d;
    logic              staged_valid_q, staged_valid_d;
    logic [OUT_W-1:0]  staged_l_q, staged_l_d;
    logic [OUT_W-1:0]  staged_r_q, staged_r_d;
    logic [OUT_W-1:0]  audio_l_q, audio_l_d;
    logic [OUT_W-1:0]  audio_r_q, audio_r_d;
    logic              audio_valid_q;
    logic [UCNT_W-1:0] underrun_cnt_q, underrun_cnt_d;

    logic [1:0]        last_idx;
    logic              is_last;
    logic              pop;
    logic              frame_done;
    logic              underrun;
    logic [OUT_W-1:0]  new_l, new_r;

    // Left-justify a 16-bit sample and zero-pad the low bits.
    function automatic logic [OUT_W-1:0] pad16(input logic [15:0] s);
        logic [OUT_W-1:0] v;
        v = '0;
        v[OUT_W-1 -: 16] = s;
        return v;
    endfunction

    always_comb begin
        last_idx = 2'd0;
        case (fmt_q)
            FMT_MONO8:    last_idx = 2'd0;
            FMT_MONO16:   last_idx = 2'd1;
            FMT_STEREO16: last_idx = 2'd3;
            FMT_STEREO8:  last_idx = 2'd1;
            default:      last_idx = 2'd0;
        endcase
    end

    assign is_last    = (byte_idx_q == last_idx);
    // The final byte may only be taken when the staging slot is free or being drained now.
    assign pop        = en_q & ~fifo_empty & (~is_last | ~staged_valid_q | audio_ack);
    assign frame_done = pop & is_last;
    assign underrun   = en_q & audio_ack & ~staged_valid_q;
    assign fifo_rena  = pop;

    // The completing byte comes straight from fifo_data, not from the assembly regs.
    always_comb begin
        new_l = '0;
        new_r = '0;
        case (fmt_q)
            FMT_MONO8: begin
                new_l = pad16({fifo_data, fifo_data});
                new_r = new_l;
            end
            FMT_MONO16: begin
                new_l = pad16({fifo_data, asm_q[0]});
                new_r = new_l;
            end
            FMT_STEREO16: begin
                new_l = pad16({asm_q[1], asm_q[0]});
                new_r = pad16({fifo_data, asm_q[2]});
            end
            FMT_STEREO8: begin
                new_l = pad16({asm_q[0], asm_q[0]});
                new_r = pad16({fifo_data, fifo_data});
            end
            default: begin
                new_l = '0;
                new_r = '0;
            end
        endcase
    end

    always_comb begin
        fmt_d          = en_q ? fmt_q : fmt;
        byte_idx_d     = byte_idx_q;
        asm_d          = asm_q;
        staged_valid_d = staged_valid_q;
        staged_l_d     = staged_l_q;
        staged_r_d     = staged_r_q;
        audio_l_d      = audio_l_q;
        audio_r_d      = audio_r_q;
        underrun_cnt_d = underrun_cnt_q;

        if (!en_q) begin
            byte_idx_d     = 2'd0;
            staged_valid_d = 1'b0;
        end else begin
            if (audio_ack && staged_valid_q) begin
                staged_valid_d = 1'b0;
            end
            if (pop) begin
                asm_d[byte_idx_q] = fifo_data;
                if (is_last) begin
                    byte_idx_d     = 2'd0;
                    staged_l_d     = new_l;
                    staged_r_d     = new_r;
                    staged_valid_d = 1'b1;
                end else begin
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end
        end

        if (audio_ack) begin
            if (en_q && staged_valid_q) begin
                audio_l_d = staged_l_q;
                audio_r_d = staged_r_q;
            end else begin
                audio_l_d = '0;
                audio_r_d = '0;
            end
        end

        if (underrun_clr) begin
            underrun_cnt_d = '0;
        end else if (underrun && (underrun_cnt_q != {UCNT_W{1'b1}})) begin
            underrun_cnt_d = underrun_cnt_q + UCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q           <= 1'b0;
            fmt_q          <= FMT_MONO8;
            byte_idx_q     <= 2'd0;
            asm_q          <= '0;
            staged_valid_q <= 1'b0;
            staged_l_q     <= '0;
            staged_r_q     <= '0;
            audio_l_q      <= '0;
            audio_r_q      <= '0;
            audio_valid_q  <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            en_q           <= enable;
            fmt_q          <= fmt_d;
            byte_idx_q     <= byte_idx_d;
            asm_q          <= asm_d;
            staged_valid_q <= staged_valid_d;
            staged_l_q     <= staged_l_d;
            staged_r_q     <= staged_r_d;
            audio_l_q      <= audio_l_d;
            audio_r_q      <= audio_r_d;
            audio_valid_q  <= enable;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign audio_l      = audio_l_q;
    assign audio_r      = audio_r_q;
    assign audio_valid  = audio_valid_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_audio_sample_unpack.sv
// Directed bench for audio_sample_unpack with a first-word-fall-through FIFO model.
module tb_audio_sample_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  fmt;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rena;
    logic [23:0] audio_l;
    logic [23:0] audio_r;
    logic        audio_valid;
    logic        audio_ack;
    logic [15:0] underrun_cnt;
    logic        underrun_clr;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fifo_mem [0:1023];
    int unsigned rd_ptr = 0;
    int unsigned wr_ptr = 0;
    int unsigned pop_cnt = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = fifo_mem[rd_ptr[9:0]];

    always @(posedge clk) begin
        if (fifo_rena) begin
            pop_cnt <= pop_cnt + 1;
            if (!fifo_empty) rd_ptr <= rd_ptr + 1;
        end
    end

    audio_sample_unpack #(
        .OUT_W  (24),
        .UCNT_W (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fmt          (fmt),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_rena    (fifo_rena),
        .audio_l      (audio_l),
        .audio_r      (audio_r),
        .audio_valid  (audio_valid),
        .audio_ack    (audio_ack),
        .underrun_cnt (underrun_cnt),
        .underrun_clr (underrun_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[9:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic ack();
        audio_ack = 1'b1;
        tick();
        audio_ack = 1'b0;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        repeat (3) tick();
        wr_ptr = rd_ptr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (audio_l !== 24'h0) begin errors++; $display("FAIL reset_l got %h want 000000", audio_l); end
        checks++; if (audio_r !== 24'h0) begin errors++; $display("FAIL reset_r got %h want 000000", audio_r); end
        checks++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", audio_valid); end
        checks++; if (underrun_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0000", underrun_cnt); end
        checks++; if (fifo_rena !== 1'b0) begin errors++; $display("FAIL reset_rena got %b want 0", fifo_rena); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mono8();
        int unsigned p0;
        fmt = 2'b00;
        p0 = pop_cnt;
        push(8'h12);
        push(8'h34);
        enable = 1'b1;
        repeat (5) tick();
        checks++; if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL m8_held_pops got %0d want 1", pop_cnt - p0); end
        checks++; if (audio_valid !== 1'b1) begin errors++; $display("FAIL m8_valid got %b want 1", audio_valid); end
        ack();
        checks++; if (audio_l !== 24'h121200) begin errors++; $display("FAIL m8_l0 got %h want 121200", audio_l); end
        checks++; if (audio_r !== 24'h121200) begin errors++; $display("FAIL m8_r0 got %h want 121200", audio_r); end
        repeat (10) tick();
        ack();
        checks++; if (audio_l !== 24'h343400) begin errors++; $display("FAIL m8_l1 got %h want 343400", audio_l); end
        checks++; if (audio_r !== 24'h343400) begin errors++; $display("FAIL m8_r1 got %h want 343400", audio_r); end
        checks++; if (pop_cnt - p0 !== 2) begin errors++; $display("FAIL m8_pops got %0d want 2", pop_cnt - p0); end
        checks++; if (underrun_cnt !== 16'h0) begin errors++; $display("FAIL m8_cnt got %h want 0000", underrun_cnt); end
        go_idle();
    endtask

    task automatic test_stereo16();
        int unsigned p0;
        fmt = 2'b10;
        p0 = pop_cnt;
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        push(8'h7F);
        enable = 1'b1;
        repeat (8) tick();
        checks++; if (pop_cnt - p0 !== 4) begin errors++; $display("FAIL s16_pops got %0d want 4", pop_cnt - p0); end
        checks++; if (fifo_rena !== 1'b0) begin errors++; $display("FAIL s16_rena got %b want 0", fifo_rena); end
        ack();
        checks++; if (audio_l !== 24'h800100) begin errors++; $display("FAIL s16_l got %h want 800100", audio_l); end
        checks++; if (audio_r !== 24'h7FFF00) begin errors++; $display("FAIL s16_r got %h want 7fff00", audio_r); end
        checks++; if (pop_cnt - p0 !== 4) begin errors++; $display("FAIL s16_pops_after got %0d want 4", pop_cnt - p0); end
        go_idle();
    endtask

    task automatic test_underrun();
        fmt = 2'b01;
        enable = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            ack();
            checks++; if (audio_l !== 24'h0) begin errors++; $display("FAIL ur_l%0d got %h want 000000", i, audio_l); end
            checks++; if (audio_r !== 24'h0) begin errors++; $display("FAIL ur_r%0d got %h want 000000", i, audio_r); end
            tick();
        end
        checks++; if (underrun_cnt !== 16'd3) begin errors++; $display("FAIL ur_cnt got %0d want 3", underrun_cnt); end
        underrun_clr = 1'b1;
        ack();
        underrun_clr = 1'b0;
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL ur_clr_wins got %0d want 0", underrun_cnt); end
        go_idle();
    endtask

    task automatic test_back_to_back();
        int unsigned p0;
        logic [7:0]  lb, rb;
        logic [23:0] exp_l, exp_r;
        fmt = 2'b11;
        p0 = pop_cnt;
        for (int k = 0; k <= 100; k++) begin
            lb = 8'(k);
            rb = 8'(k) ^ 8'hA5;
            push(lb);
            push(rb);
        end
        enable = 1'b1;
        repeat (6) tick();
        for (int k = 0; k < 100; k++) begin
            lb = 8'(k);
            rb = 8'(k) ^ 8'hA5;
            exp_l = {lb, lb, 8'h00};
            exp_r = {rb, rb, 8'h00};
            audio_ack = 1'b1;
            #1;
            checks++; if (fifo_rena !== 1'b1) begin errors++; $display("FAIL b2b_rena%0d got %b want 1", k, fifo_rena); end
            tick();
            audio_ack = 1'b0;
            checks++; if (audio_l !== exp_l) begin errors++; $display("FAIL b2b_l%0d got %h want %h", k, audio_l, exp_l); end
            checks++; if (audio_r !== exp_r) begin errors++; $display("FAIL b2b_r%0d got %h want %h", k, audio_r, exp_r); end
            tick();
        end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL b2b_cnt got %0d want 0", underrun_cnt); end
        checks++; if (pop_cnt - p0 !== 202) begin errors++; $display("FAIL b2b_pops got %0d want 202", pop_cnt - p0); end
        go_idle();
    endtask

    task automatic test_disable_restart();
        int unsigned p0, p1;
        fmt = 2'b10;
        p0 = pop_cnt;
        push(8'hA1);
        push(8'hA2);
        enable = 1'b1;
        repeat (5) tick();
        checks++; if (pop_cnt - p0 !== 2) begin errors++; $display("FAIL dis_partial_pops got %0d want 2", pop_cnt - p0); end
        enable = 1'b0;
        repeat (2) tick();
        fmt = 2'b00;
        p1 = pop_cnt;
        push(8'h55);
        tick();
        checks++; if (pop_cnt !== p1) begin errors++; $display("FAIL dis_no_pop got %0d want %0d", pop_cnt, p1); end
        enable = 1'b1;
        repeat (4) tick();
        fmt = 2'b10;
        push(8'h66);
        repeat (2) tick();
        checks++; if (pop_cnt - p1 !== 1) begin errors++; $display("FAIL dis_held_pops got %0d want 1", pop_cnt - p1); end
        ack();
        checks++; if (audio_l !== 24'h555500) begin errors++; $display("FAIL dis_l got %h want 555500", audio_l); end
        checks++; if (audio_r !== 24'h555500) begin errors++; $display("FAIL dis_r got %h want 555500", audio_r); end
        repeat (3) tick();
        ack();
        checks++; if (audio_l !== 24'h666600) begin errors++; $display("FAIL fmt_hold_l got %h want 666600", audio_l); end
        checks++; if (audio_r !== 24'h666600) begin errors++; $display("FAIL fmt_hold_r got %h want 666600", audio_r); end
        go_idle();
    endtask

    task automatic test_saturate_and_reset();
        int unsigned p0;
        fmt = 2'b00;
        enable = 1'b1;
        repeat (2) tick();
        audio_ack = 1'b1;
        repeat (65540) tick();
        checks++; if (underrun_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h want ffff", underrun_cnt); end
        tick();
        audio_ack = 1'b0;
        checks++; if (underrun_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", underrun_cnt); end
        go_idle();
        fmt = 2'b10;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        push(8'h11);
        push(8'h22);
        enable = 1'b1;
        repeat (8) tick();
        ack();
        checks++; if (audio_l !== 24'h020100) begin errors++; $display("FAIL pre_rst_l got %h want 020100", audio_l); end
        checks++; if (audio_r !== 24'h040300) begin errors++; $display("FAIL pre_rst_r got %h want 040300", audio_r); end
        checks++; if (underrun_cnt !== 16'hFFFF) begin errors++; $display("FAIL pre_rst_cnt got %h want ffff", underrun_cnt); end
        rst = 1'b1;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (audio_l !== 24'h0) begin errors++; $display("FAIL rst_l got %h want 000000", audio_l); end
        checks++; if (audio_r !== 24'h0) begin errors++; $display("FAIL rst_r got %h want 000000", audio_r); end
        checks++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", audio_valid); end
        checks++; if (underrun_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h want 0000", underrun_cnt); end
        p0 = pop_cnt;
        push(8'h77);
        #1;
        checks++; if (fifo_rena !== 1'b0) begin errors++; $display("FAIL rst_rena got %b want 0", fifo_rena); end
        tick();
        checks++; if (pop_cnt !== p0) begin errors++; $display("FAIL rst_no_pop got %0d want %0d", pop_cnt, p0); end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        fmt          = 2'b00;
        audio_ack    = 1'b0;
        underrun_clr = 1'b0;
        test_reset();
        test_mono8();
        test_stereo16();
        test_underrun();
        test_back_to_back();
        test_disable_restart();
        test_saturate_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
